// File: rtl/sw_seq_pkg.sv
// Shared definitions for the stopwatch front-end sequencer.
//
// Contents:
//   ST_IDLE / ST_RUN / ST_PAUSE / ST_LAP : 2-bit state codes, visible on the
//                                          sequencer's `state` output
//   LAP_CNT_W                            : width of the optional lap counter
//   is_counting()                        : true in the states where the
//                                          1 Hz prescaler advances
package sw_seq_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;
    localparam logic [1:0] ST_LAP   = 2'b11;

    localparam int LAP_CNT_W = 4;

    // The datapath keeps counting during a lap freeze, so the prescaler runs
    // in LAP as well as in RUN.
    function automatic logic is_counting(input logic [1:0] st);
        return (st == ST_RUN) || (st == ST_LAP);
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Debounces one raw, asynchronous, active-high push-button.
//
// A 2-flop synchronizer feeds a run-length counter. The accepted level only
// changes after DEBOUNCE_CYCLES consecutive synchronized samples that differ
// from it; any sample that agrees with the accepted level restarts the run.
// A 0->1 change of the accepted level produces a registered one-cycle event.
// Releases are debounced the same way but produce no event.
//
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   btn      in   raw button level (asynchronous)
//   rise_ev  out  one-cycle pulse, DEBOUNCE_CYCLES+2 cycles after a clean press
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise_ev
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic             level;
    logic [CNT_W-1:0] run_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1  <= 1'b0;
            sync_2  <= 1'b0;
            level   <= 1'b0;
            run_cnt <= '0;
            rise_ev <= 1'b0;
        end else begin
            sync_1  <= btn;
            sync_2  <= sync_1;
            rise_ev <= 1'b0;
            if (sync_2 == level) begin
                run_cnt <= '0;
            end else if (run_cnt == CNT_LAST) begin
                // This sample completes the run of differing samples.
                level   <= sync_2;
                run_cnt <= '0;
                rise_ev <= sync_2;
            end else begin
                run_cnt <= run_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_sequencer.sv
// Front-end controller for the stopwatch datapath.
//
// Turns the start/stop and lap/reset buttons into one-cycle command pulses,
// generates the count-enable tick every TICK_DIV cycles while counting, and
// freezes the displayed time while a lap split is shown.
//
// Build option: define LAP_COUNT_EN to add the lap_count output, a saturating
// count of RUN->LAP transitions cleared by reset and by the clear command.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   btn_ss, btn_lr            raw start/stop and lap/reset buttons
//   sw_minutes, sw_seconds    live time from the datapath
//   start_p, stop_p, clr_p    one-cycle, mutually exclusive commands
//   tick                      one-cycle count enable while in RUN or LAP
//   disp_minutes/seconds      lap snapshot in LAP, live time otherwise
//   state                     00 IDLE, 01 RUN, 10 PAUSE, 11 LAP
//   lap_count                 (LAP_COUNT_EN only) number of laps taken, max 15
module stopwatch_sequencer
    import sw_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TICK_DIV        = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_ss,
    input  logic       btn_lr,
    input  logic [7:0] sw_minutes,
    input  logic [5:0] sw_seconds,
    output logic       start_p,
    output logic       stop_p,
    output logic       clr_p,
    output logic       tick,
    output logic [7:0] disp_minutes,
    output logic [5:0] disp_seconds,
    output logic [1:0] state
`ifdef LAP_COUNT_EN
    ,
    output logic [LAP_CNT_W-1:0] lap_count
`endif
);

    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

    logic               ss_ev;
    logic               lr_ev;
    logic [1:0]         state_next;
    logic               do_start;
    logic               do_stop;
    logic               do_clr;
    logic               do_lap_cap;
    logic               counting;
    logic [PRESC_W-1:0] presc;
    logic [7:0]         lap_minutes;
    logic [5:0]         lap_seconds;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ss (
        .clk     (clk),
        .rst     (rst),
        .btn     (btn_ss),
        .rise_ev (ss_ev)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lr (
        .clk     (clk),
        .rst     (rst),
        .btn     (btn_lr),
        .rise_ev (lr_ev)
    );

    // State register; command pulses are registered alongside it so they
    // line up with the state change they announce.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            start_p <= 1'b0;
            stop_p  <= 1'b0;
            clr_p   <= 1'b0;
        end else begin
            state   <= state_next;
            start_p <= do_start;
            stop_p  <= do_stop;
            clr_p   <= do_clr;
        end
    end

    // Next-state logic. start/stop wins over lap/reset when both events land
    // in the same cycle; the losing event is simply dropped.
    always_comb begin
        state_next = state;
        do_start   = 1'b0;
        do_stop    = 1'b0;
        do_clr     = 1'b0;
        do_lap_cap = 1'b0;
        if (ss_ev) begin
            case (state)
                ST_IDLE, ST_PAUSE: begin
                    state_next = ST_RUN;
                    do_start   = 1'b1;
                end
                default: begin
                    state_next = ST_PAUSE;
                    do_stop    = 1'b1;
                end
            endcase
        end else if (lr_ev) begin
            case (state)
                ST_IDLE: begin
                    do_clr = 1'b1;
                end
                ST_RUN: begin
                    state_next = ST_LAP;
                    do_lap_cap = 1'b1;
                end
                ST_LAP: begin
                    state_next = ST_RUN;
                end
                default: begin
                    state_next = ST_IDLE;
                    do_clr     = 1'b1;
                end
            endcase
        end
    end

    // Output logic.
    always_comb begin
        counting = is_counting(state);
        tick     = counting && (presc == PRESC_LAST);
        if (state == ST_LAP) begin
            disp_minutes = lap_minutes;
            disp_seconds = lap_seconds;
        end else begin
            disp_minutes = sw_minutes;
            disp_seconds = sw_seconds;
        end
    end

    // Prescaler holds in PAUSE so a resumed run keeps its fractional second.
    always_ff @(posedge clk) begin
        if (rst || do_clr) begin
            presc <= '0;
        end else if (counting) begin
            presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lap_minutes <= '0;
            lap_seconds <= '0;
        end else if (do_lap_cap) begin
            lap_minutes <= sw_minutes;
            lap_seconds <= sw_seconds;
        end
    end

`ifdef LAP_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst || do_clr) begin
            lap_count <= '0;
        end else if (do_lap_cap && (lap_count != {LAP_CNT_W{1'b1}})) begin
            lap_count <= lap_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_stopwatch_sequencer.sv
module tb_stopwatch_sequencer;

    localparam int DB = 4;
    localparam int TD = 10;
    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_PAUSE = 2'b10;
    localparam logic [1:0] S_LAP   = 2'b11;
    localparam logic [63:0] WIN = (64'd1 << DB) - 64'd1;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_ss = 1'b0;
    logic       btn_lr = 1'b0;
    logic [7:0] sw_minutes = 8'd0;
    logic [5:0] sw_seconds = 6'd0;
    logic       start_p, stop_p, clr_p, tick;
    logic [7:0] disp_minutes;
    logic [5:0] disp_seconds;
    logic [1:0] state;
`ifdef LAP_COUNT_EN
    logic [3:0] lap_count;
`endif

    always #5 clk = ~clk;

    stopwatch_sequencer #(.DEBOUNCE_CYCLES(DB), .TICK_DIV(TD)) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_ss       (btn_ss),
        .btn_lr       (btn_lr),
        .sw_minutes   (sw_minutes),
        .sw_seconds   (sw_seconds),
        .start_p      (start_p),
        .stop_p       (stop_p),
        .clr_p        (clr_p),
        .tick         (tick),
        .disp_minutes (disp_minutes),
        .disp_seconds (disp_seconds),
        .state        (state)
`ifdef LAP_COUNT_EN
        ,
        .lap_count    (lap_count)
`endif
    );

    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    // Button path: raw level seen by the window two edges late; a new level
    // is accepted when the last DB windowed samples all disagree with the
    // current level and at least DB samples have passed since the last
    // acceptance. Timekeeping: m_acc counts clock cycles spent counting;
    // tick is expected whenever that total is one short of a multiple of TD.
    logic [1:0]  m_state;
    logic        m_start, m_stop, m_clr;
    int          m_acc;
    logic [7:0]  m_lap_min;
    logic [5:0]  m_lap_sec;
    int          m_lap_cnt;
    logic [1:0]  m_rsync [2];
    logic [63:0] m_hist [2];
    int          m_since [2];
    logic        m_lvl [2];
    logic        m_ev [2];
    logic        m_raw [2];
    logic [1:0]  m_old;
    logic        m_s;
    logic [1:0]  exp_q[$];

    always @(posedge clk) begin
        if (rst) begin
            m_state = S_IDLE; m_start = 1'b0; m_stop = 1'b0; m_clr = 1'b0;
            m_acc = 0; m_lap_min = '0; m_lap_sec = '0; m_lap_cnt = 0;
            for (int b = 0; b < 2; b++) begin
                m_rsync[b] = '0; m_hist[b] = '0; m_since[b] = 0;
                m_lvl[b] = 1'b0; m_ev[b] = 1'b0;
            end
        end else begin
            m_old = m_state;
            m_start = 1'b0; m_stop = 1'b0; m_clr = 1'b0;
            if (m_old == S_RUN || m_old == S_LAP) m_acc++;
            if (m_ev[0]) begin
                if (m_old == S_IDLE || m_old == S_PAUSE) begin
                    m_state = S_RUN; m_start = 1'b1;
                end else begin
                    m_state = S_PAUSE; m_stop = 1'b1;
                end
            end else if (m_ev[1]) begin
                if (m_old == S_IDLE) m_clr = 1'b1;
                else if (m_old == S_RUN) begin
                    m_state = S_LAP; m_lap_min = sw_minutes; m_lap_sec = sw_seconds;
                    if (m_lap_cnt < 15) m_lap_cnt++;
                end else if (m_old == S_LAP) m_state = S_RUN;
                else begin
                    m_state = S_IDLE; m_clr = 1'b1;
                end
            end
            if (m_clr) begin m_acc = 0; m_lap_cnt = 0; end
            if (m_start) exp_q.push_back(2'd1);
            if (m_stop)  exp_q.push_back(2'd2);
            if (m_clr)   exp_q.push_back(2'd3);
            m_raw[0] = btn_ss;
            m_raw[1] = btn_lr;
            for (int b = 0; b < 2; b++) begin
                m_s = m_rsync[b][1];
                m_rsync[b] = {m_rsync[b][0], m_raw[b]};
                m_hist[b] = {m_hist[b][62:0], m_s};
                m_since[b]++;
                m_ev[b] = 1'b0;
                if (m_since[b] >= DB && ((m_hist[b] & WIN) == (m_lvl[b] ? 64'd0 : WIN))) begin
                    m_lvl[b] = ~m_lvl[b];
                    m_since[b] = 0;
                    m_ev[b] = m_lvl[b];
                end
            end
        end
    end

    logic        m_tick;
    logic [13:0] m_disp;
    logic [19:0] mdl_vec;
    logic [19:0] dut_vec;
    logic [1:0]  dut_code;
    assign m_tick   = (m_state == S_RUN || m_state == S_LAP) && ((m_acc % TD) == (TD - 1));
    assign m_disp   = (m_state == S_LAP) ? {m_lap_min, m_lap_sec} : {sw_minutes, sw_seconds};
    assign mdl_vec  = {m_state, m_start, m_stop, m_clr, m_tick, m_disp};
    assign dut_vec  = {state, start_p, stop_p, clr_p, tick, disp_minutes, disp_seconds};
    assign dut_code = start_p ? 2'd1 : stop_p ? 2'd2 : clr_p ? 2'd3 : 2'd0;

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        btn_ss = 1'b0;
        btn_lr = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        btn_ss = 1'($urandom_range(0, 1));
        btn_lr = 1'($urandom_range(0, 1));
        sw_minutes = 8'($urandom_range(0, 255));
        sw_seconds = 6'($urandom_range(0, 59));
        repeat (3) @(negedge clk);
        total++;
        if (state !== S_IDLE) begin bad++; $display("FAIL reset_state: got %b want %b", state, S_IDLE); end
        total++;
        if ({start_p, stop_p, clr_p, tick} !== 4'b0) begin
            bad++; $display("FAIL reset_pulses: got %b want 0000", {start_p, stop_p, clr_p, tick});
        end
        total++;
        if ({disp_minutes, disp_seconds} !== {sw_minutes, sw_seconds}) begin
            bad++; $display("FAIL reset_disp: got %h want %h", {disp_minutes, disp_seconds}, {sw_minutes, sw_seconds});
        end
`ifdef LAP_COUNT_EN
        total++;
        if (lap_count !== 4'd0) begin bad++; $display("FAIL reset_lapcnt: got %0d want 0", lap_count); end
`endif
        do_reset();
    endtask

    task automatic test_start();
        do_reset();
        for (int i = 0; i < 45; i++) begin
            total++;
            if (dut_vec !== mdl_vec) begin bad++; $display("FAIL start_model[%0d]: got %h want %h", i, dut_vec, mdl_vec); end
            total++;
            if (start_p !== (i == 7)) begin bad++; $display("FAIL start_pulse[%0d]: got %b want %b", i, start_p, (i == 7)); end
            total++;
            if (tick !== (i >= 16 && ((i - 16) % 10) == 0)) begin
                bad++; $display("FAIL start_tick[%0d]: got %b", i, tick);
            end
            if (i >= 7) begin
                total++;
                if (state !== S_RUN) begin bad++; $display("FAIL start_state[%0d]: got %b want %b", i, state, S_RUN); end
            end
            btn_ss = (i < 20);
            @(negedge clk);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        for (int i = 0; i < 35; i++) begin
            total++;
            if (dut_vec !== mdl_vec) begin bad++; $display("FAIL glitch_model[%0d]: got %h want %h", i, dut_vec, mdl_vec); end
            total++;
            if ({state, start_p, stop_p, clr_p} !== 5'b0) begin
                bad++; $display("FAIL glitch_idle[%0d]: got %b want 00000", i, {state, start_p, stop_p, clr_p});
            end
            btn_ss = (i < 20) && ((i % 4) != 3);
            @(negedge clk);
        end
    endtask

    task automatic test_lap();
        do_reset();
        for (int i = 0; i < 100; i++) begin
            total++;
            if (dut_vec !== mdl_vec) begin bad++; $display("FAIL lap_model[%0d]: got %h want %h", i, dut_vec, mdl_vec); end
            if (i >= 40 && i < 70) begin
                total++;
                if ({state, disp_minutes, disp_seconds} !== {S_LAP, 8'd3, 6'd42}) begin
                    bad++; $display("FAIL lap_hold[%0d]: got %h want %h", i, {state, disp_minutes, disp_seconds}, {S_LAP, 8'd3, 6'd42});
                end
            end
            if (i >= 80) begin
                total++;
                if ({state, disp_minutes, disp_seconds} !== {S_RUN, sw_minutes, sw_seconds}) begin
                    bad++; $display("FAIL lap_live[%0d]: got %h want %h", i, {state, disp_minutes, disp_seconds}, {S_RUN, sw_minutes, sw_seconds});
                end
            end
            btn_ss = (i < 8);
            btn_lr = (i >= 30 && i < 38) || (i >= 70 && i < 78);
            if (i == 20) begin sw_minutes = 8'd3; sw_seconds = 6'd42; end
            if (i == 45) sw_seconds = 6'd43;
            if (i == 50) sw_seconds = 6'd44;
            if (i == 55) sw_seconds = 6'd45;
            if (i >= 85) sw_seconds = 6'(i - 40);
            @(negedge clk);
        end
    endtask

    task automatic test_pause();
        do_reset();
        for (int i = 0; i < 140; i++) begin
            total++;
            if (dut_vec !== mdl_vec) begin bad++; $display("FAIL pause_model[%0d]: got %h want %h", i, dut_vec, mdl_vec); end
            total++;
            if (tick !== (i == 16 || i == 26 || i == 60 || i == 70 || i == 126 || i == 136)) begin
                bad++; $display("FAIL pause_tick[%0d]: got %b", i, tick);
            end
            total++;
            if ({start_p, stop_p, clr_p} !== {(i == 7 || i == 57 || i == 117), (i == 33 || i == 77), (i == 97)}) begin
                bad++; $display("FAIL pause_cmd[%0d]: got %b", i, {start_p, stop_p, clr_p});
            end
            if (i == 40 || i == 90) begin
                total++;
                if (state !== S_PAUSE) begin bad++; $display("FAIL pause_state[%0d]: got %b want %b", i, state, S_PAUSE); end
            end
            if (i == 100) begin
                total++;
                if (state !== S_IDLE) begin bad++; $display("FAIL pause_clr_state[%0d]: got %b want %b", i, state, S_IDLE); end
            end
            btn_ss = (i < 8) || (i >= 26 && i < 34) || (i >= 50 && i < 58) ||
                     (i >= 70 && i < 78) || (i >= 110 && i < 118);
            btn_lr = (i >= 90 && i < 98);
            @(negedge clk);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int i = 0; i < 25; i++) begin
            total++;
            if (dut_vec !== mdl_vec) begin bad++; $display("FAIL simul_model[%0d]: got %h want %h", i, dut_vec, mdl_vec); end
            total++;
            if ({start_p, stop_p, clr_p} !== {(i == 7), 1'b0, 1'b0}) begin
                bad++; $display("FAIL simul_cmd[%0d]: got %b", i, {start_p, stop_p, clr_p});
            end
            if (i >= 7) begin
                total++;
                if (state !== S_RUN) begin bad++; $display("FAIL simul_state[%0d]: got %b want %b", i, state, S_RUN); end
            end
            btn_ss = (i < 8);
            btn_lr = (i < 8);
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_lap();
        do_reset();
        sw_minutes = 8'd7;
        sw_seconds = 6'd11;
        for (int i = 0; i < 70; i++) begin
            total++;
            if (dut_vec !== mdl_vec) begin bad++; $display("FAIL rstlap_model[%0d]: got %h want %h", i, dut_vec, mdl_vec); end
            if (i == 32) begin
                total++;
                if (state !== S_LAP) begin bad++; $display("FAIL rstlap_pre[%0d]: got %b want %b", i, state, S_LAP); end
            end
            if (i == 33) begin
                total++;
                if ({state, tick, disp_minutes, disp_seconds} !== {S_IDLE, 1'b0, sw_minutes, sw_seconds}) begin
                    bad++; $display("FAIL rstlap_post[%0d]: got %h want %h", i, {state, tick, disp_minutes, disp_seconds}, {S_IDLE, 1'b0, sw_minutes, sw_seconds});
                end
`ifdef LAP_COUNT_EN
                total++;
                if (lap_count !== 4'd0) begin bad++; $display("FAIL rstlap_cnt: got %0d want 0", lap_count); end
`endif
            end
            if (i >= 33) begin
                total++;
                if (tick !== (i == 56 || i == 66)) begin bad++; $display("FAIL rstlap_tick[%0d]: got %b", i, tick); end
            end
            btn_ss = (i < 8) || (i >= 40 && i < 48);
            btn_lr = (i >= 20 && i < 28);
            rst = (i == 32);
            if (i == 29) sw_seconds = 6'd12;
            @(negedge clk);
        end
    endtask

`ifdef LAP_COUNT_EN
    task automatic test_lap_count();
        do_reset();
        for (int i = 0; i < 20 + 34 * 16 + 10; i++) begin
            total++;
            if (lap_count !== 4'(m_lap_cnt)) begin bad++; $display("FAIL lapcnt_model[%0d]: got %0d want %0d", i, lap_count, m_lap_cnt); end
            btn_ss = (i < 8);
            btn_lr = (i >= 20) && (((i - 20) % 16) < 8) && (((i - 20) / 16) < 34);
            @(negedge clk);
        end
        total++;
        if (lap_count !== 4'd15) begin bad++; $display("FAIL lapcnt_sat: got %0d want 15", lap_count); end
    endtask
`endif

    task automatic test_random();
        int ss_hold = 0;
        int lr_hold = 0;
        do_reset();
        exp_q.delete();
        for (int i = 0; i < 3000; i++) begin
            total++;
            if (dut_vec !== mdl_vec) begin bad++; $display("FAIL rand_model[%0d]: got %h want %h", i, dut_vec, mdl_vec); end
            if (dut_code != 2'd0) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL rand_cmd[%0d]: got %0d want none", i, dut_code);
                end else if (exp_q[0] !== dut_code) begin
                    bad++; $display("FAIL rand_cmd[%0d]: got %0d want %0d", i, dut_code, exp_q[0]);
                end
            end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            total++;
            if (exp_q.size() != 0) begin
                bad++; $display("FAIL rand_cmd_missing[%0d]: got %0d queued want 0", i, exp_q.size());
                exp_q.delete();
            end
`ifdef LAP_COUNT_EN
            total++;
            if (lap_count !== 4'(m_lap_cnt)) begin bad++; $display("FAIL rand_lapcnt[%0d]: got %0d want %0d", i, lap_count, m_lap_cnt); end
`endif
            if (ss_hold == 0) begin btn_ss = ~btn_ss; ss_hold = $urandom_range(1, 14); end
            else ss_hold--;
            if (lr_hold == 0) begin btn_lr = ~btn_lr; lr_hold = $urandom_range(1, 14); end
            else lr_hold--;
            if ($urandom_range(0, 7) == 0) begin
                sw_minutes = 8'($urandom_range(0, 255));
                sw_seconds = 6'($urandom_range(0, 59));
            end
            rst = ($urandom_range(0, 599) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        test_reset();
        test_start();
        test_glitch();
        test_lap();
        test_pause();
        test_simultaneous();
        test_reset_mid_lap();
`ifdef LAP_COUNT_EN
        test_lap_count();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
